ysyx_22041461_core_seq: RTL and testbench

Multi-cycle sequencer for the existing IDU/ADDER/REGS datapath; replaces the free-running PC.
- Owns the PC and fetches each instruction over a valid/ready handshake to instruction memory.
- Presents the latched instruction to the IDU and gates the register-file write enable to a single writeback cycle.
- Halts on the ebreak flag and raises a sticky error on fetch timeout.

---
 rtl/ysyx_22041461_pkg.sv | 18 +
 rtl/ysyx_22041461_core_seq_fetch_wdog.sv | 26 ++
 rtl/ysyx_22041461_core_seq.sv | 154 +++++++++++++++
 tb/tb_ysyx_22041461_core_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041461_pkg.sv
// Shared definitions for the core sequencer: state encoding, reset PC and nop.
package ysyx_22041461_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH_REQ  = 3'd1,
        ST_FETCH_WAIT = 3'd2,
        ST_EXEC       = 3'd3,
        ST_WB         = 3'd4,
        ST_HALT       = 3'd5,
        ST_ERROR      = 3'd6
    } state_t;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [63:0] PC_STEP          = 64'd4;

endpackage

// File: rtl/ysyx_22041461_core_seq_fetch_wdog.sv
// Fetch watchdog: counts cycles spent fetching and flags when TIMEOUT is reached.
module ysyx_22041461_fetch_wdog #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [CNT_W-1:0] count;

    // Counter: cleared on reset or on entry to a fetch, advances while fetching.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire = (count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/ysyx_22041461_core_seq.sv
// Multi-cycle core sequencer: owns the PC, fetches over valid/ready, gates the
// register write to the WB cycle, halts on ebreak, errors on fetch timeout.
// Optional performance counters built when YSYX_22041461_PERF_CNT_EN is defined.
module ysyx_22041461_core_seq
    import ysyx_22041461_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req_valid,
    output logic [63:0] ifu_req_addr,
    input  logic        ifu_req_ready,
    input  logic        ifu_rsp_valid,
    input  logic [31:0] ifu_rsp_inst,
    output logic        ifu_rsp_ready,
    output logic [31:0] inst,
    input  logic        en_regw_in,
    output logic        regw_en,
    input  logic        halt_in,
    output logic [63:0] pc,
    output logic        retire,
    output logic        halted,
    output logic        err,
    output logic [63:0] mcycle,
    output logic [63:0] minstret
);

    state_t state, state_next;
    logic   wdog_clr, wdog_en, wdog_expire;
    logic   inst_load, pc_inc;

    ysyx_22041461_fetch_wdog #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) u_wdog (
        .clk   (clk),
        .rst   (rst),
        .clr   (wdog_clr),
        .en    (wdog_en),
        .expire(wdog_expire)
    );

    assign ifu_req_addr = pc;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control outputs; a completed handshake beats the timeout.
    always_comb begin
        state_next    = state;
        ifu_req_valid = 1'b0;
        ifu_rsp_ready = 1'b0;
        regw_en       = 1'b0;
        retire        = 1'b0;
        halted        = 1'b0;
        err           = 1'b0;
        wdog_clr      = 1'b0;
        wdog_en       = 1'b0;
        inst_load     = 1'b0;
        pc_inc        = 1'b0;
        case (state)
            ST_IDLE: begin
                wdog_clr   = 1'b1;
                state_next = ST_FETCH_REQ;
            end
            ST_FETCH_REQ: begin
                ifu_req_valid = 1'b1;
                wdog_en       = 1'b1;
                if (ifu_req_ready) begin
                    state_next = ST_FETCH_WAIT;
                end else if (wdog_expire) begin
                    state_next = ST_ERROR;
                end
            end
            ST_FETCH_WAIT: begin
                ifu_rsp_ready = 1'b1;
                wdog_en       = 1'b1;
                if (ifu_rsp_valid) begin
                    inst_load  = 1'b1;
                    state_next = ST_EXEC;
                end else if (wdog_expire) begin
                    state_next = ST_ERROR;
                end
            end
            ST_EXEC: begin
                if (halt_in) begin
                    retire     = 1'b1;
                    state_next = ST_HALT;
                end else begin
                    state_next = ST_WB;
                end
            end
            ST_WB: begin
                regw_en    = en_regw_in;
                retire     = 1'b1;
                pc_inc     = 1'b1;
                wdog_clr   = 1'b1;
                state_next = ST_FETCH_REQ;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            ST_ERROR: begin
                err = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // PC and latched instruction; PC advances by 4 in WB and wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc   <= RESET_PC;
            inst <= INST_NOP;
        end else begin
            if (pc_inc) begin
                pc <= pc + PC_STEP;
            end
            if (inst_load) begin
                inst <= ifu_rsp_inst;
            end
        end
    end

`ifdef YSYX_22041461_PERF_CNT_EN
    // Performance counters: cycles since reset and retired instructions.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            mcycle <= mcycle + 64'd1;
            if (retire) begin
                minstret <= minstret + 64'd1;
            end
        end
    end
`else
    assign mcycle   = '0;
    assign minstret = '0;
`endif

endmodule

// File: tb/tb_ysyx_22041461_core_seq.sv
// Scoreboard bench for ysyx_22041461_core_seq: expected retirements are queued
// by the stimulus and checked by a monitor on each retire pulse.
module tb_ysyx_22041461_core_seq;

`ifdef YSYX_22041461_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
    logic [63:0] ifu_req_addr, pc, mcycle, minstret;
    logic [31:0] ifu_rsp_inst, inst;
    logic        en_regw_in = 1'b1;
    logic        regw_en, halt_in, retire, halted, err;

    logic        rst2 = 1'b1;
    logic        req_valid2, rsp_ready2, regw_en2, retire2, halted2, err2;
    logic [63:0] req_addr2, pc2, mcycle2, minstret2;
    logic [31:0] inst2;

    always #5 clk = ~clk;

    ysyx_22041461_core_seq dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr), .ifu_req_ready(ifu_req_ready),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_inst(ifu_rsp_inst), .ifu_rsp_ready(ifu_rsp_ready),
        .inst(inst), .en_regw_in(en_regw_in), .regw_en(regw_en), .halt_in(halt_in),
        .pc(pc), .retire(retire), .halted(halted), .err(err),
        .mcycle(mcycle), .minstret(minstret)
    );

    ysyx_22041461_core_seq #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst2),
        .ifu_req_valid(req_valid2), .ifu_req_addr(req_addr2), .ifu_req_ready(req_valid2),
        .ifu_rsp_valid(rsp_ready2), .ifu_rsp_inst(32'h0000_0093), .ifu_rsp_ready(rsp_ready2),
        .inst(inst2), .en_regw_in(1'b1), .regw_en(regw_en2), .halt_in(1'b0),
        .pc(pc2), .retire(retire2), .halted(halted2), .err(err2),
        .mcycle(mcycle2), .minstret(minstret2)
    );

    // Instruction memory model: ready after req_wait stall cycles, inst derived from address.
    int          req_wait  = 0;
    bit          rsp_on    = 1'b1;
    bit          rsp_force = 1'b0;
    bit          halt_mode = 1'b0;
    int          wcnt      = 0;
    logic [63:0] lat_addr  = '0;

    always @(posedge clk) begin
        if (ifu_req_valid && !ifu_req_ready) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (ifu_req_valid && ifu_req_ready) lat_addr <= ifu_req_addr;
    end

    assign ifu_req_ready = ifu_req_valid && (wcnt >= req_wait);
    assign ifu_rsp_valid = (ifu_rsp_ready && rsp_on) || rsp_force;
    assign ifu_rsp_inst  = rsp_force ? 32'hDEAD_BEEF : {lat_addr[13:2], 20'h08093};
    assign halt_in       = halt_mode && (inst == 32'h0010_8093);

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned vectors = 0;
    int unsigned fails   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        regw;
    } exp_t;

    exp_t        sb[$];
    int unsigned retire_cnt = 0;
    int unsigned ret_cyc[8];

    // Monitor: pop and compare on every retire pulse; regw_en must coincide with retire.
    always @(negedge clk) begin
        if (!rst) begin
            if (retire) begin
                if (sb.size() == 0) begin
                    check("unexpected_retire", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("retire_pc", pc, e.pc);
                    check("retire_inst", {32'd0, inst}, {32'd0, e.inst});
                    check("retire_regw", {63'd0, regw_en}, {63'd0, e.regw});
                end
                if (retire_cnt < 8) ret_cyc[retire_cnt] = cyc;
                retire_cnt++;
            end
            if (regw_en) check("regw_outside_wb", {63'd0, retire}, 64'd1);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        repeat (2) step();
        sb.delete();
        retire_cnt = 0;
    endtask

    task automatic wait_retires(input int unsigned n, input int unsigned bound);
        for (int unsigned i = 0; i < bound && retire_cnt < n; i++) step();
        if (retire_cnt < n) check("retire_wait_expired", {32'd0, retire_cnt}, {32'd0, n});
    endtask

    task automatic wait_req(input int unsigned bound);
        for (int unsigned i = 0; i < bound && !ifu_req_valid; i++) step();
        if (!ifu_req_valid) check("req_wait_expired", 64'd0, 64'd1);
    endtask

    initial begin
        bit any_req, any_regw;
        int first_err;

        // Reset state
        reset_dut();
        check("rst_pc", pc, 64'h0000_0000_8000_0000);
        check("rst_inst", {32'd0, inst}, 64'h13);
        check("rst_ctrl", {58'd0, ifu_req_valid, ifu_rsp_ready, retire, regw_en, halted, err}, 64'd0);
        check("rst_mcycle", mcycle, 64'd0);
        check("rst_minstret", minstret, 64'd0);

        // Zero-wait ADDI stream
        sb.push_back('{64'h0000_0000_8000_0000, 32'h0000_8093, 1'b1});
        sb.push_back('{64'h0000_0000_8000_0004, 32'h0010_8093, 1'b1});
        sb.push_back('{64'h0000_0000_8000_0008, 32'h0020_8093, 1'b1});
        rst = 1'b0;
        repeat (5) step();
        check("mcycle_5", mcycle, PERF_EN ? 64'd5 : 64'd0);
        wait_retires(3, 60);
        check("minstret_2", minstret, PERF_EN ? 64'd2 : 64'd0);
        check("retire_gap_1", {32'd0, ret_cyc[1] - ret_cyc[0]}, 64'd4);
        check("retire_gap_2", {32'd0, ret_cyc[2] - ret_cyc[1]}, 64'd4);
        reset_dut();

        // Request held 3 cycles before ready
        req_wait = 3;
        sb.push_back('{64'h0000_0000_8000_0000, 32'h0000_8093, 1'b1});
        rst = 1'b0;
        wait_req(10);
        for (int j = 0; j < 4; j++) begin
            check("stall_req_valid", {63'd0, ifu_req_valid}, 64'd1);
            check("stall_req_addr", ifu_req_addr, 64'h0000_0000_8000_0000);
            step();
        end
        check("stall_after_valid", {63'd0, ifu_req_valid}, 64'd0);
        check("stall_after_rsp_ready", {63'd0, ifu_rsp_ready}, 64'd1);
        wait_retires(1, 20);
        reset_dut();
        req_wait = 0;

        // Halt in EXEC of the second instruction
        halt_mode = 1'b1;
        sb.push_back('{64'h0000_0000_8000_0000, 32'h0000_8093, 1'b1});
        sb.push_back('{64'h0000_0000_8000_0004, 32'h0010_8093, 1'b0});
        rst = 1'b0;
        wait_retires(2, 40);
        step();
        check("halt_halted", {63'd0, halted}, 64'd1);
        check("halt_pc", pc, 64'h0000_0000_8000_0004);
        any_req = 1'b0;
        any_regw = 1'b0;
        repeat (10) begin
            any_req  |= ifu_req_valid;
            any_regw |= regw_en;
            step();
        end
        check("halt_no_req", {63'd0, any_req}, 64'd0);
        check("halt_no_regw", {63'd0, any_regw}, 64'd0);
        check("halt_sticky", {63'd0, halted}, 64'd1);
        reset_dut();
        halt_mode = 1'b0;
        check("halt_cleared", {63'd0, halted}, 64'd0);

        // Fetch timeout: response never arrives
        rsp_on = 1'b0;
        rst = 1'b0;
        wait_req(10);
        first_err = -1;
        for (int i = 0; i < 400; i++) begin
            if (err) begin
                first_err = i;
                break;
            end
            step();
        end
        check("timeout_cycle", 64'(first_err), 64'd256);
        any_req = 1'b0;
        repeat (20) begin
            any_req |= ifu_req_valid;
            step();
        end
        check("err_sticky", {63'd0, err}, 64'd1);
        check("err_no_req", {63'd0, any_req}, 64'd0);
        reset_dut();
        check("err_cleared", {63'd0, err}, 64'd0);

        // Reset during FETCH_WAIT, late response ignored
        rsp_on = 1'b1;
        sb.push_back('{64'h0000_0000_8000_0000, 32'h0000_8093, 1'b1});
        rst = 1'b0;
        wait_retires(1, 20);
        rsp_on = 1'b0;
        wait_req(10);
        step();
        check("mid_rsp_ready", {63'd0, ifu_rsp_ready}, 64'd1);
        rst = 1'b1;
        step();
        check("mid_rst_pc", pc, 64'h0000_0000_8000_0000);
        check("mid_rst_inst", {32'd0, inst}, 64'h13);
        rst = 1'b0;
        rsp_force = 1'b1;
        step();
        rsp_force = 1'b0;
        check("late_rsp_inst", {32'd0, inst}, 64'h13);
        check("late_rsp_req_valid", {63'd0, ifu_req_valid}, 64'd1);
        check("late_rsp_pc", pc, 64'h0000_0000_8000_0000);
        reset_dut();
        rsp_on = 1'b1;

        // PC wrap from the top of the address space
        rst2 = 1'b0;
        for (int i = 0; i < 20 && !retire2; i++) step();
        check("wrap_retire_seen", {63'd0, retire2}, 64'd1);
        check("wrap_pc_before", pc2, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_regw", {63'd0, regw_en2}, 64'd1);
        step();
        check("wrap_pc_after", pc2, 64'd0);
        check("wrap_minstret", minstret2, PERF_EN ? 64'd1 : 64'd0);
        rst2 = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
